// File: rtl/addsub_seq_ctrl_if.sv
// Handshake and data bundle between the datapath sequencer and addsub_seq_ctrl.
// The slave modport is the controller side; the master modport is the sequencer side.
interface addsub_seq_ctrl_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         start_valid;
    logic         start_ready;
    logic         m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         busy;

    modport slave (
        input  start_valid, m, a, b, res_ready,
        output start_ready, res_valid, result, cout, ovf, busy
    );

    modport master (
        output start_valid, m, a, b, res_ready,
        input  start_ready, res_valid, result, cout, ovf, busy
    );
endinterface

// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: runs one shared 8-bit add/sub slice across an NBYTES-wide
// operand pair, least-significant byte first, one byte per clock.
// Optional feature macro: ADDSUB_SAT_EN (saturate result on signed overflow).
module addsub_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic             clk,
    input  logic             rst,
    addsub_seq_ctrl_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            m_q, m_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            c_q, c_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            res_valid_q, res_valid_d;

    // Byte slice: operand bytes selected by idx, B conditionally inverted.
    logic [IW+2:0]   bit_base;
    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [7:0]      beff_byte;
    logic [8:0]      s9;
    logic            beff_msb;
    logic            ovf_n;

    assign bit_base  = {idx_q, 3'b000};
    assign a_byte    = a_q[bit_base +: 8];
    assign b_byte    = b_q[bit_base +: 8];
    assign beff_byte = m_q ? ~b_byte : b_byte;
    assign s9        = {1'b0, a_byte} + {1'b0, beff_byte} + {8'd0, c_q};

    // Overflow is only meaningful on the top byte, where s9[7] is the result sign.
    assign beff_msb  = m_q ? ~b_q[W-1] : b_q[W-1];
    assign ovf_n     = (a_q[W-1] == beff_msb) && (s9[7] != a_q[W-1]);

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            m_q         <= 1'b0;
            idx_q       <= '0;
            c_q         <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            m_q         <= m_d;
            idx_q       <= idx_d;
            c_q         <= c_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Next-state and datapath update: capture in IDLE, one byte per RUN cycle, hold in DONE.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        m_d         = m_q;
        idx_d       = idx_q;
        c_d         = c_q;
        result_d    = result_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        res_valid_d = res_valid_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    m_d     = bus.m;
                    idx_d   = '0;
                    // Carry-in of 1 supplies the +1 of two's-complement subtract.
                    c_d     = bus.m;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[bit_base +: 8] = s9[7:0];
                c_d   = s9[8];
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d      = s9[8];
                    ovf_d       = ovf_n;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef ADDSUB_SAT_EN
                    // Clamp toward the sign of A, which is the sign both operands share.
                    if (ovf_n) begin
                        result_d = a_q[W-1] ? {1'b1, {(W-1){1'b0}}}
                                            : {1'b0, {(W-1){1'b1}}};
                    end
`else
                    // Wrapped modulo-2^W result is kept as computed.
`endif
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.busy        = (state_q == RUN) || (state_q == DONE);
    assign bus.res_valid   = res_valid_q;
    assign bus.result      = result_q;
    assign bus.cout        = cout_q;
    assign bus.ovf         = ovf_q;
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench for addsub_seq_ctrl: directed vector table, backpressure
// and mid-run reset sequences, then randomized operations against a model.
module tb_addsub_seq_ctrl;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;
`ifdef ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    addsub_seq_ctrl_if #(.NBYTES(NBYTES)) bus ();

    addsub_seq_ctrl #(.NBYTES(NBYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         m;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed/unsigned arithmetic on wide integers, no byte slicing.
    task automatic model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic c, output logic o);
        longint ua, ub, sa, sb, ures, sres;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (m) begin
            ures = ua - ub;
            sres = sa - sb;
            c    = (ua >= ub);
        end else begin
            ures = ua + ub;
            sres = sa + sb;
            c    = (ures >= (64'sd1 << W));
        end
        o = (sres > longint'(32'sh7FFF_FFFF)) || (sres < -(64'sd1 <<< (W-1)));
        r = ures[W-1:0];
        if (SAT && o) r = (sres > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
    endtask

    // Issue one command, wait for res_valid (bounded), capture, then handshake after 'dly' cycles.
    task automatic run_op(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int dly,
                          output logic [W-1:0] r, output logic c, output logic o, output int lat);
        int guard;
        guard = 0;
        while (bus.start_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.m = m; bus.a = a; bus.b = b; bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        bus.a = '1; bus.b = '1; bus.m = ~m;  // disturb inputs while in flight
        lat = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (bus.res_valid === 1'b1) begin
                lat = cyc;
                break;
            end
        end
        r = bus.result; c = bus.cout; o = bus.ovf;
        repeat (dly) begin @(posedge clk); #1; end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    vec_t         vecs[8];
    logic [W-1:0] r, er, r0;
    logic         c, o, ec, eo, c0, o0;
    int           lat;
    logic         stable;

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        bus.start_valid = 1'b0; bus.m = 1'b0; bus.a = '0; bus.b = '0; bus.res_ready = 1'b0;

        vecs[0] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001,
                    SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001,
                    SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 32'h8000_0000, 32'h8000_0000,
                    SAT ? 32'h8000_0000 : 32'h0000_0000, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_result", bus.result, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_start_ready", bus.start_ready, 1);

        // Directed vector table.
        foreach (vecs[i]) begin
            run_op(vecs[i].m, vecs[i].a, vecs[i].b, i % 3, r, c, o, lat);
            check($sformatf("vec%0d_lat", i), lat, NBYTES);
            check($sformatf("vec%0d_result", i), r, vecs[i].exp_res);
            check($sformatf("vec%0d_cout", i), c, vecs[i].exp_cout);
            check($sformatf("vec%0d_ovf", i), o, vecs[i].exp_ovf);
        end

        // Backpressure: result held, no second command accepted while DONE.
        bus.m = 1'b0; bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        check("bp_busy_run", bus.busy, 1);
        lat = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (bus.res_valid === 1'b1) begin lat = cyc; break; end
        end
        check("bp_lat", lat, NBYTES);
        r0 = bus.result; c0 = bus.cout; o0 = bus.ovf;
        check("bp_result", r0, 32'h2345_6789);
        for (int k = 0; k < 10; k++) begin
            bus.start_valid = k[0]; bus.a = $urandom; bus.b = $urandom; bus.m = $urandom_range(0, 1);
            @(posedge clk); #1;
            stable = (bus.result === r0) && (bus.cout === c0) && (bus.ovf === o0) &&
                     (bus.res_valid === 1'b1) && (bus.start_ready === 1'b0) && (bus.busy === 1'b1);
            check($sformatf("bp_hold%0d", k), stable, 1);
        end
        bus.start_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        check("bp_release_valid", bus.res_valid, 0);
        check("bp_release_ready", bus.start_ready, 1);
        run_op(1'b0, 32'h0000_0003, 32'h0000_0004, 0, r, c, o, lat);
        check("bp_next_result", r, 32'h0000_0007);

        // Reset during the second RUN cycle aborts the operation.
        bus.m = 1'b0; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_start_ready", bus.start_ready, 1);
        check("mrst_busy", bus.busy, 0);
        check("mrst_res_valid", bus.res_valid, 0);
        check("mrst_result", bus.result, 0);
        check("mrst_cout_ovf", {bus.cout, bus.ovf}, 0);
        run_op(1'b0, 32'h0000_0001, 32'h0000_0001, 1, r, c, o, lat);
        check("mrst_add_result", r, 32'h0000_0002);
        check("mrst_add_lat", lat, NBYTES);

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic         rm;
            logic [W-1:0] ra, rb;
            rm = $urandom_range(0, 1);
            ra = $urandom;
            rb = $urandom;
            if (n % 5 == 0) ra = {ra[W-1], {(W-1){ra[0]}}};
            if (n % 7 == 0) rb = {rb[W-1], {(W-1){rb[1]}}};
            model(rm, ra, rb, er, ec, eo);
            run_op(rm, ra, rb, $urandom_range(0, 3), r, c, o, lat);
            check($sformatf("rnd%0d_lat", n), lat, NBYTES);
            check($sformatf("rnd%0d_res m=%0d a=%h b=%h", n, rm, ra, rb), r, er);
            check($sformatf("rnd%0d_cout", n), c, ec);
            check($sformatf("rnd%0d_ovf", n), o, eo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
